// File: rtl/bpu_pkg.sv
// Shared types and helpers for the IF-stage branch predictor: update kinds,
// saturating-counter constants and PC-to-index/tag extraction.
package bpu_pkg;

    typedef enum logic [1:0] {
        UPD_BR   = 2'd0,
        UPD_JAL  = 2'd1,
        UPD_JALR = 2'd2,
        UPD_NONE = 2'd3
    } upd_type_e;

    // Weakly not-taken: the value just below the MSB threshold.
    function automatic int cnt_reset_val(input int cnt_w);
        return (1 << (cnt_w - 1)) - 1;
    endfunction

    function automatic int cnt_max_val(input int cnt_w);
        return (1 << cnt_w) - 1;
    endfunction

    function automatic logic [63:0] pc_index(input logic [63:0] pc, input int idx_w);
        return (pc >> 2) & ((64'd1 << idx_w) - 64'd1);
    endfunction

    function automatic logic [63:0] pc_tag(input logic [63:0] pc, input int idx_w, input int tag_w);
        return (pc >> (idx_w + 2)) & ((64'd1 << tag_w) - 64'd1);
    endfunction

endpackage

// File: rtl/bpu_sat_counter.sv
// One saturating up/down counter of the pattern table; increment wins if both
// requests are raised, and reset returns it to weakly not-taken.
module bpu_sat_counter
    import bpu_pkg::*;
#(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] RST_VAL = CNT_W'(cnt_reset_val(CNT_W));
    localparam logic [CNT_W-1:0] MAX_VAL = CNT_W'(cnt_max_val(CNT_W));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= RST_VAL;
        end else if (inc && (cnt != MAX_VAL)) begin
            cnt <= cnt + CNT_W'(1);
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB plus bimodal/gshare pattern table; combinational lookup
// from the IF PC, trained by EX resolution, with speculative global history.
module branch_predictor
    import bpu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 64,
    parameter int TAG_W   = 8,
    parameter int CNT_W   = 2,
    parameter int MODE    = 0,
    parameter int GHR_W   = 6,
    parameter int PERF_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [XLEN-1:0]   pc_if_i,
    input  logic              stall_i,
    output logic              pred_taken_o,
    output logic [XLEN-1:0]   pred_target_o,
    output logic [GHR_W-1:0]  pred_ghr_o,
    input  logic              upd_valid_i,
    input  upd_type_e         upd_type_i,
    input  logic [XLEN-1:0]   upd_pc_i,
    input  logic              upd_taken_i,
    input  logic [XLEN-1:0]   upd_target_i,
    input  logic              upd_pred_taken_i,
    input  logic [XLEN-1:0]   upd_pred_target_i,
    input  logic [GHR_W-1:0]  upd_ghr_i,
    output logic              mispredict_o,
    output logic [PERF_W-1:0] br_cnt_o,
    output logic [PERF_W-1:0] mispred_cnt_o
);

    localparam int IDX_W = $clog2(ENTRIES);

    logic              btb_valid  [ENTRIES];
    logic [TAG_W-1:0]  btb_tag    [ENTRIES];
    logic [XLEN-1:0]   btb_target [ENTRIES];
    logic              btb_is_jal [ENTRIES];
    logic [CNT_W-1:0]  pt_cnt     [ENTRIES];
    logic [ENTRIES-1:0] pt_inc, pt_dec;

    logic [GHR_W-1:0]  ghr;
    logic [PERF_W-1:0] br_cnt, mispred_cnt;

    logic [IDX_W-1:0]  lk_idx, lk_pt_idx, upd_idx, upd_pt_idx;
    logic [TAG_W-1:0]  lk_tag, upd_tag;
    logic              lk_hit, lk_is_jal, upd_active, btb_write;

    assign lk_idx     = IDX_W'(pc_index(64'(pc_if_i), IDX_W));
    assign lk_tag     = TAG_W'(pc_tag(64'(pc_if_i), IDX_W, TAG_W));
    assign upd_idx    = IDX_W'(pc_index(64'(upd_pc_i), IDX_W));
    assign upd_tag    = TAG_W'(pc_tag(64'(upd_pc_i), IDX_W, TAG_W));
    assign lk_pt_idx  = (MODE == 1) ? (lk_idx ^ IDX_W'(ghr)) : lk_idx;
    assign upd_pt_idx = (MODE == 1) ? (upd_idx ^ IDX_W'(upd_ghr_i)) : upd_idx;

    assign lk_is_jal     = btb_is_jal[lk_idx];
    assign lk_hit        = btb_valid[lk_idx] && (btb_tag[lk_idx] == lk_tag);
    assign pred_taken_o  = rst_n && lk_hit && (lk_is_jal || pt_cnt[lk_pt_idx][CNT_W-1]);
    assign pred_target_o = pred_taken_o ? btb_target[lk_idx] : (pc_if_i + XLEN'(4));
    assign pred_ghr_o    = ghr;

    assign upd_active   = upd_valid_i && (upd_type_i != UPD_NONE);
    assign mispredict_o = upd_active &&
                          ((upd_pred_taken_i != upd_taken_i) ||
                           (upd_taken_i && (upd_pred_target_i != upd_target_i)));
    // JALR targets vary per call site, so they never occupy a BTB entry.
    assign btb_write    = rst_n && upd_active && upd_taken_i &&
                          ((upd_type_i == UPD_BR) || (upd_type_i == UPD_JAL));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) btb_valid[i] <= 1'b0;
        end else if (btb_write) begin
            btb_valid[upd_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (btb_write) begin
            btb_tag[upd_idx]    <= upd_tag;
            btb_target[upd_idx] <= upd_target_i;
            btb_is_jal[upd_idx] <= (upd_type_i == UPD_JAL);
        end
    end

    always_comb begin
        pt_inc = '0;
        pt_dec = '0;
        if (upd_valid_i && (upd_type_i == UPD_BR)) begin
            if (upd_taken_i) pt_inc[upd_pt_idx] = 1'b1;
            else             pt_dec[upd_pt_idx] = 1'b1;
        end
    end

    for (genvar g = 0; g < ENTRIES; g++) begin : g_pt
        bpu_sat_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .inc   (pt_inc[g]),
            .dec   (pt_dec[g]),
            .cnt   (pt_cnt[g])
        );
    end

    // Repair from EX outranks the speculative shift made by this cycle's lookup.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ghr <= '0;
        end else if (mispredict_o && (upd_type_i == UPD_BR)) begin
            ghr <= GHR_W'({upd_ghr_i, upd_taken_i});
        end else if (mispredict_o) begin
            ghr <= upd_ghr_i;
        end else if (!stall_i && lk_hit && !lk_is_jal) begin
            ghr <= GHR_W'({ghr, pred_taken_o});
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            br_cnt      <= '0;
            mispred_cnt <= '0;
        end else begin
            if (upd_active)   br_cnt      <= br_cnt + PERF_W'(1);
            if (mispredict_o) mispred_cnt <= mispred_cnt + PERF_W'(1);
        end
    end

    assign br_cnt_o      = br_cnt;
    assign mispred_cnt_o = mispred_cnt;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench: a bimodal and a gshare predictor driven by the same stimulus.
module tb_branch_predictor;
    import bpu_pkg::*;

    logic        clk, rst_n, stall;
    logic [31:0] pc_if;
    logic        upd_valid;
    upd_type_e   upd_type;
    logic [31:0] upd_pc, upd_target, upd_pred_target;
    logic        upd_taken, upd_pred_taken;
    logic [5:0]  upd_ghr;

    logic        b_pred_taken, b_mispredict, g_pred_taken, g_mispredict;
    logic [31:0] b_pred_target, g_pred_target, b_br_cnt, b_mp_cnt, g_br_cnt, g_mp_cnt;
    logic [5:0]  b_pred_ghr, g_pred_ghr;

    int checks = 0;
    int errors = 0;

    branch_predictor #(.MODE(0)) u_bimodal (
        .clk(clk), .rst_n(rst_n), .pc_if_i(pc_if), .stall_i(stall),
        .pred_taken_o(b_pred_taken), .pred_target_o(b_pred_target), .pred_ghr_o(b_pred_ghr),
        .upd_valid_i(upd_valid), .upd_type_i(upd_type), .upd_pc_i(upd_pc),
        .upd_taken_i(upd_taken), .upd_target_i(upd_target),
        .upd_pred_taken_i(upd_pred_taken), .upd_pred_target_i(upd_pred_target),
        .upd_ghr_i(upd_ghr), .mispredict_o(b_mispredict),
        .br_cnt_o(b_br_cnt), .mispred_cnt_o(b_mp_cnt)
    );

    branch_predictor #(.MODE(1)) u_gshare (
        .clk(clk), .rst_n(rst_n), .pc_if_i(pc_if), .stall_i(stall),
        .pred_taken_o(g_pred_taken), .pred_target_o(g_pred_target), .pred_ghr_o(g_pred_ghr),
        .upd_valid_i(upd_valid), .upd_type_i(upd_type), .upd_pc_i(upd_pc),
        .upd_taken_i(upd_taken), .upd_target_i(upd_target),
        .upd_pred_taken_i(upd_pred_taken), .upd_pred_target_i(upd_pred_target),
        .upd_ghr_i(upd_ghr), .mispredict_o(g_mispredict),
        .br_cnt_o(g_br_cnt), .mispred_cnt_o(g_mp_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [31:0] pc);
        upd_valid = 1'b0;
        upd_type  = UPD_NONE;
        upd_taken = 1'b0;
        upd_pred_taken = 1'b0;
        pc_if = pc;
        #1;
    endtask

    task automatic upd(input upd_type_e t, input logic [31:0] pc, input logic tk,
                       input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt,
                       input logic [5:0] gh);
        upd_valid = 1'b1;
        upd_type = t;
        upd_pc = pc;
        upd_taken = tk;
        upd_target = tgt;
        upd_pred_taken = ptk;
        upd_pred_target = ptgt;
        upd_ghr = gh;
        #1;
    endtask

    logic        p_t;
    logic [31:0] p_tg;
    logic [5:0]  p_g;

    initial begin
        rst_n = 1'b0;
        stall = 1'b0;
        pc_if = 32'h200;
        upd(UPD_BR, 32'h200, 1'b1, 32'h180, 1'b0, 32'h204, 6'd0);
        tick();
        chk("rst_pred_taken", b_pred_taken, 0);
        chk("rst_pred_target", b_pred_target, 32'h204);
        tick();
        rst_n = 1'b1;
        idle(32'h100);
        chk("cold_taken", b_pred_taken, 0);
        chk("cold_target", b_pred_target, 32'h104);
        chk("cold_br_cnt", b_br_cnt, 0);
        chk("cold_mp_cnt", b_mp_cnt, 0);
        idle(32'h200);
        chk("rst_discard_upd", b_pred_taken, 0);

        // Taken BR training on 0x200 -> 0x180
        upd(UPD_BR, 32'h200, 1'b1, 32'h180, 1'b0, 32'h204, 6'd0);
        chk("br_first_mispredict", b_mispredict, 1);
        tick();
        idle(32'h200);
        chk("br_trained_taken", b_pred_taken, 1);
        chk("br_trained_target", b_pred_target, 32'h180);
        chk("br_cnt_1", b_br_cnt, 1);
        chk("mp_cnt_1", b_mp_cnt, 1);
        upd(UPD_BR, 32'h200, 1'b0, 32'h180, 1'b1, 32'h180, 6'd0);
        chk("br_nt_mispredict", b_mispredict, 1);
        tick();
        idle(32'h200);
        chk("br_nt_taken", b_pred_taken, 0);
        chk("br_nt_target", b_pred_target, 32'h204);

        // Lookup and update of the same entry in one cycle
        upd(UPD_BR, 32'h200, 1'b1, 32'h180, 1'b0, 32'h204, 6'd0);
        chk("same_cycle_old_pred", b_pred_taken, 0);
        chk("same_cycle_mispredict", b_mispredict, 1);
        tick();
        idle(32'h200);
        chk("same_cycle_next", b_pred_taken, 1);
        upd(UPD_BR, 32'h200, 1'b1, 32'h180, 1'b1, 32'h180, 6'd0);
        chk("br_correct_no_mp", b_mispredict, 0);
        tick();
        upd(UPD_BR, 32'h200, 1'b1, 32'h180, 1'b1, 32'h180, 6'd0);
        tick();
        upd(UPD_BR, 32'h200, 1'b0, 32'h180, 1'b1, 32'h180, 6'd0);
        tick();
        idle(32'h200);
        chk("saturate_high", b_pred_taken, 1);
        chk("br_cnt_6", b_br_cnt, 6);
        chk("mp_cnt_4", b_mp_cnt, 4);

        // Aliasing and JAL
        idle(32'h300);
        chk("alias_miss", b_pred_taken, 0);
        chk("alias_target", b_pred_target, 32'h304);
        upd(UPD_JAL, 32'h300, 1'b1, 32'h400, 1'b0, 32'h304, 6'd0);
        chk("jal_mispredict", b_mispredict, 1);
        tick();
        idle(32'h300);
        chk("jal_taken", b_pred_taken, 1);
        chk("jal_target", b_pred_target, 32'h400);
        idle(32'h200);
        chk("evicted_taken", b_pred_taken, 0);
        chk("evicted_target", b_pred_target, 32'h204);
        pc_if = 32'h104;
        upd(UPD_BR, 32'h200, 1'b0, 32'h180, 1'b0, 32'h204, 6'd0);
        chk("nt_correct_no_mp", b_mispredict, 0);
        tick();
        upd(UPD_BR, 32'h200, 1'b0, 32'h180, 1'b0, 32'h204, 6'd0);
        tick();
        idle(32'h300);
        chk("jal_no_cnt_dep", b_pred_taken, 1);
        chk("jal_no_cnt_dep_tgt", b_pred_target, 32'h400);

        // JALR is never predicted
        idle(32'h500);
        chk("jalr_miss", b_pred_taken, 0);
        chk("jalr_miss_tgt", b_pred_target, 32'h504);
        upd(UPD_JALR, 32'h500, 1'b1, 32'h600, 1'b0, 32'h504, 6'd0);
        chk("jalr_mp_1", b_mispredict, 1);
        tick();
        upd(UPD_JALR, 32'h500, 1'b1, 32'h600, 1'b0, 32'h504, 6'd0);
        chk("jalr_mp_2", b_mispredict, 1);
        tick();
        idle(32'h500);
        chk("jalr_not_alloc", b_pred_taken, 0);
        idle(32'h300);
        chk("jalr_keeps_btb", b_pred_taken, 1);
        upd(UPD_NONE, 32'h300, 1'b1, 32'h999, 1'b0, 32'h304, 6'd0);
        chk("none_no_mp", b_mispredict, 0);
        tick();
        idle(32'h104);
        chk("br_cnt_11", b_br_cnt, 11);
        chk("mp_cnt_7", b_mp_cnt, 7);

        // gshare history repair and stall
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        idle(32'h104);
        upd(UPD_BR, 32'h200, 1'b1, 32'h180, 1'b0, 32'h204, 6'd0);
        chk("g_first_mp", g_mispredict, 1);
        tick();
        idle(32'h104);
        chk("g_ghr_repair_1", g_pred_ghr, 6'b000001);
        pc_if = 32'h200;
        upd(UPD_BR, 32'h200, 1'b1, 32'h180, 1'b0, 32'h204, 6'b000101);
        chk("g_spec_hit_miss_pred", g_pred_taken, 0);
        chk("g_forced_mp", g_mispredict, 1);
        tick();
        idle(32'h104);
        chk("g_ghr_repair_2", g_pred_ghr, 6'b001011);
        stall = 1'b1;
        idle(32'h200);
        tick();
        stall = 1'b0;
        idle(32'h104);
        chk("g_stall_hold", g_pred_ghr, 6'b001011);
        idle(32'h200);
        tick();
        idle(32'h104);
        chk("g_spec_shift", g_pred_ghr, 6'b010110);

        // Alternating branch converges in gshare
        for (int k = 0; k < 40; k++) begin
            idle(32'h200);
            p_t  = g_pred_taken;
            p_tg = g_pred_target;
            p_g  = g_pred_ghr;
            tick();
            pc_if = 32'h104;
            upd(UPD_BR, 32'h200, ((k % 2) == 0), 32'h180, p_t, p_tg, p_g);
            if (k >= 20) chk("g_alt_converged", g_mispredict, 0);
            tick();
        end

        // Reset in a cycle carrying an update
        rst_n = 1'b0;
        pc_if = 32'h300;
        upd(UPD_JAL, 32'h700, 1'b1, 32'h800, 1'b0, 32'h704, 6'd0);
        chk("rst_mid_target", b_pred_target, 32'h304);
        tick();
        rst_n = 1'b1;
        idle(32'h700);
        chk("rst_mid_no_alloc", b_pred_taken, 0);
        chk("rst_mid_br_cnt", b_br_cnt, 0);
        chk("rst_mid_mp_cnt", b_mp_cnt, 0);
        chk("rst_mid_g_br_cnt", g_br_cnt, 0);
        chk("rst_mid_g_ghr", g_pred_ghr, 0);
        idle(32'h200);
        chk("rst_mid_valid_clr", b_pred_taken, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
